// File: rtl/stage_ctrl_pkg.sv
// Shared definitions for the stage-4 sequencer: stage-4 out_flag encodings and
// the controller state type.
package stage_ctrl_pkg;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_ONE  = 2'b01;
  localparam logic [1:0] FLAG_HOLD = 2'b10;
  localparam logic [1:0] FLAG_TWO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/stage_4_ctrl_if.sv
// Bundle of the stage-4 result handshake, byte output stream and frame
// control/status signals around stage_4_ctrl.
interface stage_4_ctrl_if #(
  parameter int OUTPUT_DATA_WIDTH = 8
);
  logic                         start;
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic [1:0]                   in_flag;
  logic [OUTPUT_DATA_WIDTH-1:0] in_byte_1;
  logic [OUTPUT_DATA_WIDTH-1:0] in_byte_2;
  logic [OUTPUT_DATA_WIDTH-1:0] in_hold;
  logic [OUTPUT_DATA_WIDTH-1:0] prev_bitstream;
  logic [OUTPUT_DATA_WIDTH-1:0] out_byte;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;
  logic                         busy;
  logic                         done;

  modport slave (
    input  start, in_valid, in_last, in_flag, in_byte_1, in_byte_2, in_hold,
           out_ready,
    output in_ready, prev_bitstream, out_byte, out_valid, out_last, busy, done
  );

  modport master (
    output start, in_valid, in_last, in_flag, in_byte_1, in_byte_2, in_hold,
           out_ready,
    input  in_ready, prev_bitstream, out_byte, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/bitstream_out_fifo.sv
// Synchronous FIFO of {last, byte} entries: up to two pushes and one pop per
// cycle, head presented from registered storage, zero when empty.
module bitstream_out_fifo #(
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_AW           = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   push_cnt,
  input  logic [OUTPUT_DATA_WIDTH:0]   push_d0,
  input  logic [OUTPUT_DATA_WIDTH:0]   push_d1,
  input  logic                         pop,
  output logic [OUTPUT_DATA_WIDTH-1:0] head_byte,
  output logic                         head_last,
  output logic [FIFO_AW:0]             count
);

  logic [OUTPUT_DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [OUTPUT_DATA_WIDTH:0] head_entry;
  logic [FIFO_AW-1:0]         wr_ptr;
  logic [FIFO_AW-1:0]         rd_ptr;
  logic                       pop_en;
  logic                       empty;

  assign empty  = (count == '0);
  assign pop_en = pop && !empty;

  // NOTE: storage has no reset; the pointers/count define validity and the
  // head is forced to zero while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr] <= push_d0;
    if (push_cnt[1])      mem[wr_ptr + FIFO_AW'(1)] <= push_d1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push_cnt);
      rd_ptr <= rd_ptr + FIFO_AW'(pop_en);
      count  <= count + (FIFO_AW+1)'(push_cnt) - (FIFO_AW+1)'(pop_en);
    end
  end

  assign head_entry = empty ? '0 : mem[rd_ptr];
  assign head_byte  = head_entry[OUTPUT_DATA_WIDTH-1:0];
  assign head_last  = head_entry[OUTPUT_DATA_WIDTH];

endmodule

// File: rtl/stage_4_ctrl.sv
// Frame sequencer around stage 4: owns the previous/hold byte, accepts results,
// queues emitted bytes and flushes the final held byte tagged as last.
module stage_4_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_AW           = 2
) (
  input  logic         clk,
  input  logic         reset,
  stage_4_ctrl_if.slave bus
);

  localparam int W  = OUTPUT_DATA_WIDTH;
  localparam int CW = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_t         state, state_nxt;
  logic [W-1:0]   prev_q;
  logic           hold_valid;
  logic [CW-1:0]  count;
  logic [1:0]     push_cnt;
  logic [W:0]     push_d0, push_d1;
  logic           ready;
  logic           accept;
  logic           done;
  logic           pop;

  // Free-space decisions use the registered count, so a same-cycle pop never
  // opens acceptance early.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    push_cnt  = 2'd0;
    push_d0   = {1'b0, bus.in_byte_1};
    push_d1   = {1'b0, bus.in_byte_2};
    done      = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN: begin
        ready  = (count <= DEPTH_C - CW'(2));
        accept = bus.in_valid && ready;
        if (accept) begin
          if (bus.in_flag == FLAG_TWO)      push_cnt = 2'd2;
          else if (bus.in_flag == FLAG_ONE) push_cnt = 2'd1;
          if (bus.in_last) begin
            state_nxt = ST_FLUSH;
            // With nothing held afterwards, the byte pushed now ends the frame.
            if (!(hold_valid || bus.in_flag[1])) begin
              push_d0[W] = (bus.in_flag == FLAG_ONE);
              push_d1[W] = 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (!hold_valid) begin
          state_nxt = ST_DRAIN;
        end else if (count < DEPTH_C) begin
          push_cnt  = 2'd1;
          push_d0   = {1'b1, prev_q};
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count == '0) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      prev_q     <= '0;
      hold_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.start) begin
        prev_q     <= '0;
        hold_valid <= 1'b0;
      end
      if (accept && bus.in_flag != FLAG_NONE) prev_q     <= bus.in_hold;
      if (accept && bus.in_flag[1])           hold_valid <= 1'b1;
    end
  end

  assign pop = bus.out_ready && (count != '0);

  bitstream_out_fifo #(
    .OUTPUT_DATA_WIDTH (W),
    .FIFO_DEPTH        (FIFO_DEPTH),
    .FIFO_AW           (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_cnt  (push_cnt),
    .push_d0   (push_d0),
    .push_d1   (push_d1),
    .pop       (pop),
    .head_byte (bus.out_byte),
    .head_last (bus.out_last),
    .count     (count)
  );

  assign bus.in_ready       = ready;
  assign bus.prev_bitstream = prev_q;
  assign bus.out_valid      = (count != '0);
  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = done;

endmodule

// File: tb/tb_stage_4_ctrl.sv
// Directed bench for stage_4_ctrl: hand-computed byte streams, handshake
// back-pressure, flush tagging and mid-frame reset.
module tb_stage_4_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  stage_4_ctrl_if #(.OUTPUT_DATA_WIDTH(8)) bus ();

  stage_4_ctrl #(
    .OUTPUT_DATA_WIDTH (8),
    .FIFO_DEPTH        (4),
    .FIFO_AW           (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; samples/drives happen 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic valid, input logic last, input logic [1:0] flag,
                          input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] hold);
    bus.in_valid  = valid;
    bus.in_last   = last;
    bus.in_flag   = flag;
    bus.in_byte_1 = b1;
    bus.in_byte_2 = b2;
    bus.in_hold   = hold;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  logic [7:0] exp_q [4];

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_byte",  32'(bus.out_byte),  32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_prev",      32'(bus.prev_bitstream), 32'd0);
    reset = 1'b0;

    // in_valid in IDLE is ignored
    drive_in(1'b1, 1'b0, 2'b11, 8'hEE, 8'hEF, 8'hF0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("idle_no_push", 32'(bus.out_valid), 32'd0);
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);

    // Two-byte result
    start_frame();
    check("run_busy",     32'(bus.busy),     32'd1);
    check("run_in_ready", 32'(bus.in_ready), 32'd1);
    drive_in(1'b1, 1'b0, 2'b11, 8'h12, 8'h34, 8'h56);
    tick();
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    check("t1_head0",  32'(bus.out_byte),  32'h12);
    check("t1_valid0", 32'(bus.out_valid), 32'd1);
    check("t1_prev",   32'(bus.prev_bitstream), 32'h56);
    tick();
    check("t1_head1", 32'(bus.out_byte), 32'h34);
    check("t1_last1", 32'(bus.out_last), 32'd0);
    tick();
    check("t1_empty", 32'(bus.out_valid), 32'd0);

    // One-byte result
    drive_in(1'b1, 1'b0, 2'b01, 8'hAA, 8'h55, 8'h77);
    tick();
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    check("t2_head", 32'(bus.out_byte), 32'hAA);
    check("t2_prev", 32'(bus.prev_bitstream), 32'h77);
    tick();
    check("t2_single", 32'(bus.out_valid), 32'd0);

    // Hold-only last result, flush pushes the held byte as last
    drive_in(1'b1, 1'b1, 2'b10, 8'h11, 8'h22, 8'h9C);
    tick();
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    check("t3_flush_empty", 32'(bus.out_valid), 32'd0);
    check("t3_flush_ready", 32'(bus.in_ready),  32'd0);
    tick();
    check("t3_byte", 32'(bus.out_byte), 32'h9C);
    check("t3_last", 32'(bus.out_last), 32'd1);
    check("t3_done_early", 32'(bus.done), 32'd0);
    tick();
    check("t3_done", 32'(bus.done), 32'd1);
    tick();
    check("t3_done_pulse", 32'(bus.done), 32'd0);
    check("t3_idle", 32'(bus.busy), 32'd0);

    // Back-pressure: FIFO fills after two two-byte accepts
    start_frame();
    bus.out_ready = 1'b0;
    drive_in(1'b1, 1'b0, 2'b11, 8'h01, 8'h02, 8'h03);
    tick();
    check("t4_ready_half", 32'(bus.in_ready), 32'd1);
    drive_in(1'b1, 1'b0, 2'b11, 8'h04, 8'h05, 8'h33);
    tick();
    check("t4_ready_full", 32'(bus.in_ready), 32'd0);
    drive_in(1'b1, 1'b0, 2'b11, 8'h06, 8'h07, 8'h08);
    tick();
    check("t4_still_full", 32'(bus.in_ready), 32'd0);
    check("t4_prev", 32'(bus.prev_bitstream), 32'h33);
    bus.out_ready = 1'b1;
    #1;
    check("t4_pop_no_accept", 32'(bus.in_ready), 32'd0);
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h04; exp_q[3] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("t4_byte%0d", i),  32'(bus.out_byte),  32'(exp_q[i]));
      tick();
      if (i == 0) drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    end
    check("t4_drained", 32'(bus.out_valid), 32'd0);
    drive_in(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 8'h00);
    tick();
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    tick();
    check("t4_flush_byte", 32'(bus.out_byte), 32'h33);
    check("t4_flush_last", 32'(bus.out_last), 32'd1);
    tick();
    check("t4_done", 32'(bus.done), 32'd1);
    tick();

    // Last tag on the in-cycle byte when nothing is held
    start_frame();
    drive_in(1'b1, 1'b1, 2'b01, 8'h3E, 8'h00, 8'h44);
    tick();
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    check("t5_byte", 32'(bus.out_byte), 32'h3E);
    check("t5_last", 32'(bus.out_last), 32'd1);
    tick();
    check("t5_no_extra", 32'(bus.out_valid), 32'd0);
    check("t5_done", 32'(bus.done), 32'd1);
    tick();
    check("t5_idle", 32'(bus.busy), 32'd0);

    // Reset in FLUSH with three bytes queued
    start_frame();
    bus.out_ready = 1'b0;
    drive_in(1'b1, 1'b0, 2'b11, 8'hA1, 8'hA2, 8'hA3);
    tick();
    drive_in(1'b1, 1'b1, 2'b01, 8'hB1, 8'h00, 8'hB3);
    tick();
    drive_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    check("t6_busy", 32'(bus.busy), 32'd1);
    check("t6_queued_head", 32'(bus.out_byte), 32'hA1);
    reset = 1'b1;
    tick();
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_busy_rst",  32'(bus.busy),      32'd0);
    check("t6_prev",      32'(bus.prev_bitstream), 32'd0);
    check("t6_done",      32'(bus.done),      32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t6_no_done", 32'(bus.done), 32'd0);
    check("t6_empty",   32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_4_ctrl.md
Name: stage_4_ctrl

Overview:
- Sequencer wrapped around the stage-4 bitstream combiner of the arithmetic-encoder pipeline.
- Owns the previous-byte/hold register that feeds stage 4's in_previous_bitstream.
- Consumes stage-4 results under a valid/ready handshake, buffers the emitted bytes in a small FIFO and streams them to the byte output.
- Runs the end-of-frame flush that emits the last held byte tagged as last.

Parameters:
- OUTPUT_DATA_WIDTH, 8, byte width of the previous, hold and output bytes.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- FIFO_AW, 2, FIFO address width; must equal log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse, honoured only in IDLE; begins a frame.
- in_valid  in  1  stage-4 result valid.
- in_ready  out  1  controller accepts the stage-4 result this cycle.
- in_last  in  1  result is the final one of the frame.
- in_flag  in  2  stage-4 out_flag: 00 none, 01 byte1 only, 10 hold only, 11 byte1+byte2.
- in_byte_1  in  OUTPUT_DATA_WIDTH  stage-4 out_bitstream_1.
- in_byte_2  in  OUTPUT_DATA_WIDTH  stage-4 out_bitstream_2.
- in_hold  in  OUTPUT_DATA_WIDTH  stage-4 bitstream_hold.
- prev_bitstream  out  OUTPUT_DATA_WIDTH  registered hold byte driven to stage-4 in_previous_bitstream.
- out_byte  out  OUTPUT_DATA_WIDTH  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts out_byte.
- out_last  out  1  FIFO head is the last byte of the frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- Reset values, in the cycle after reset is sampled high:
  - state=IDLE; prev_bitstream=0; hold_valid=0.
  - FIFO empty, so out_valid=0, out_byte=0, out_last=0.
  - in_ready=0, busy=0, done=0.
- Reset asserted mid-frame aborts immediately. FIFO contents are discarded and no done pulse is produced.
- States: IDLE, RUN, FLUSH, DRAIN.
- IDLE:
  - in_ready=0.
  - On start: prev_bitstream<=0, hold_valid<=0, go to RUN.
- RUN:
  - in_ready = (FIFO free entries >= 2). The FIFO is always able to take a worst-case two-byte result.
  - in_ready does not depend on in_valid.
  - Accept = in_valid & in_ready.
  - On accept:
    - flag[0]=1: push in_byte_1.
    - flag=11: also push in_byte_2 behind byte_1, same cycle.
    - flag!=00: prev_bitstream<=in_hold.
    - flag[1]=1: hold_valid<=1.
    - flag=00: no push; prev_bitstream and hold_valid unchanged.
  - in_last accepted -> FLUSH.
- FLUSH:
  - in_ready=0.
  - If hold_valid: wait until free entries >= 1, push prev_bitstream with last tag set, then go to DRAIN.
  - If not hold_valid:
    - If a byte was pushed in the in_last cycle, it carries the last tag instead.
    - If the frame emitted nothing, no last byte exists.
    - Go straight to DRAIN.
- DRAIN:
  - Wait for FIFO empty.
  - Then pulse done for one cycle and go to IDLE.
- Output stream:
  - out_valid=!empty.
  - Pop on out_valid & out_ready.
  - out_byte and out_last are registered FIFO head outputs; no combinational path from out_ready to out_byte.
- Latency: a byte accepted in cycle N is at the head of an otherwise empty FIFO with out_valid=1 in cycle N+1.
- Full FIFO with simultaneous pop: free-space checks use the count registered at the start of the cycle, so a same-cycle pop does not enable acceptance.
- Simultaneous push and pop are legal in every state.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- start outside IDLE is ignored. in_valid outside RUN is ignored; no result is lost because in_ready=0.
- No arithmetic is performed here; all carry arithmetic stays in stage 4.

Decomposition:
- Shared package stage_ctrl_pkg holds:
  - flag encodings: FLAG_NONE=2'b00, FLAG_ONE=2'b01, FLAG_HOLD=2'b10, FLAG_TWO=2'b11.
  - state enum for IDLE/RUN/FLUSH/DRAIN.
- One sub-module, bitstream_out_fifo:
  - synchronous FIFO of {last, byte}, FIFO_DEPTH entries.
  - push of 0, 1 or 2 entries per cycle; single pop per cycle.
  - exposes count.

Test Plan:
- Reset, then start; accept flag=11 with byte1=0x12, byte2=0x34, hold=0x56 and out_ready=1 -> out stream 0x12 then 0x34; prev_bitstream=0x56 one cycle after accept.
- Accept flag=01 byte1=0xAA, hold=0x77 (in_last=0) -> only 0xAA emitted; prev_bitstream=0x77; hold_valid unchanged.
- Accept flag=10 hold=0x9C with in_last=1 -> FLUSH pushes 0x9C with out_last=1; done pulses one cycle after the FIFO empties; state returns to IDLE.
- Hold out_ready=0 and drive back-to-back flag=11 results -> after two accepts (FIFO_DEPTH=4) in_ready=0; raise out_ready -> bytes drain in order with none lost or duplicated.
- First result flag=01 byte1=0x3E with in_last=1, hold_valid=0 -> 0x3E emitted with out_last=1; no extra byte.
- Assert reset while in FLUSH with 3 bytes queued -> next cycle out_valid=0, busy=0, prev_bitstream=0, no done pulse.
